// File: rtl/hc_csr.sv
// rtl/hc_csr.sv - HardCloud MMIO CSR file: register decode, control FSM and MMIO read responses
// Optional HC_CSR_READBACK_EN makes the DSM, control and buffer registers readable.
module hc_csr #(
   parameter int          NUM_BUFFERS = 2,
   parameter logic [63:0] AFU_ID_L    = 64'h0,
   parameter logic [63:0] AFU_ID_H    = 64'h0
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      cp2af_mmio_rd_valid,
   input  logic                      cp2af_mmio_wr_valid,
   input  logic [15:0]               cp2af_mmio_address,
   input  logic [8:0]                cp2af_mmio_tid,
   input  logic [63:0]               cp2af_mmio_data,
   output logic                      af2cp_mmio_rd_valid,
   output logic [8:0]                af2cp_mmio_tid,
   output logic [63:0]               af2cp_mmio_data,
   output logic [63:0]               hc_dsm_base,
   output logic [NUM_BUFFERS*64-1:0] hc_buffer_address,
   output logic [NUM_BUFFERS*32-1:0] hc_buffer_size,
   output logic [31:0]               hc_control,
   output logic                      hc_soft_reset,
   output logic                      hc_start,
   output logic                      hc_running
);

   localparam logic [63:0] DFH = {4'h1, 19'h0, 1'b1, 40'h0};

   typedef enum logic [1:0] {
      S_CTL_RESET = 2'd0,
      S_CTL_IDLE  = 2'd1,
      S_CTL_RUN   = 2'd2
   } ctl_state_t;

   ctl_state_t  state_q, state_d;
   logic        start_q, start_d;
   logic [63:0] dsm_q;
   logic [31:0] ctl_q;
   logic [63:0] buf_addr_q [NUM_BUFFERS];
   logic [31:0] buf_size_q [NUM_BUFFERS];
   logic        rd_valid_q;
   logic [8:0]  rd_tid_q;
   logic [63:0] rd_data_q, rd_data_d;

   // Host addresses are DWORD based; only the first 1 KiB of byte space is decoded.
   logic [17:0] byte_addr;
   logic        in_range, is_dsm, is_ctl, is_buf, size_sel;
   logic [5:0]  buf_idx;

   assign byte_addr = {cp2af_mmio_address, 2'b00};
   assign in_range  = (cp2af_mmio_address[15:8] == 8'h00);
   assign is_dsm    = in_range && (byte_addr == 18'h110);
   assign is_ctl    = in_range && (byte_addr == 18'h118);
   assign buf_idx   = 6'((byte_addr - 18'h120) >> 4);
   assign is_buf    = in_range && (byte_addr >= 18'h120) && ({1'b0, buf_idx} < 7'(NUM_BUFFERS));
   assign size_sel  = cp2af_mmio_address[1];

   always_comb begin
      state_d = state_q;
      start_d = 1'b0;
      if (cp2af_mmio_wr_valid && is_ctl) begin
         if (cp2af_mmio_data[31:0] == 32'h0) begin
            state_d = S_CTL_RESET;
         end else begin
            case (state_q)
               S_CTL_RESET: if (cp2af_mmio_data[31:0] == 32'h1) state_d = S_CTL_IDLE;
               S_CTL_IDLE:  if (cp2af_mmio_data[31:0] == 32'h3) begin
                               state_d = S_CTL_RUN;
                               start_d = 1'b1;
                            end
               S_CTL_RUN:   if (cp2af_mmio_data[31:0] == 32'h7) state_d = S_CTL_IDLE;
               default:     state_d = S_CTL_RESET;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_CTL_RESET;
         start_q <= 1'b0;
      end else begin
         state_q <= state_d;
         start_q <= start_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         dsm_q <= '0;
         ctl_q <= '0;
         for (int i = 0; i < NUM_BUFFERS; i++) begin
            buf_addr_q[i] <= '0;
            buf_size_q[i] <= '0;
         end
      end else if (cp2af_mmio_wr_valid) begin
         if (is_dsm) dsm_q <= cp2af_mmio_data;
         if (is_ctl) ctl_q <= cp2af_mmio_data[31:0];
         for (int i = 0; i < NUM_BUFFERS; i++) begin
            if (is_buf && buf_idx == 6'(i)) begin
               if (size_sel) buf_size_q[i] <= cp2af_mmio_data[31:0];
               else          buf_addr_q[i] <= cp2af_mmio_data;
            end
         end
      end
   end

   // Read data comes from the current register contents, so a same-cycle write is not visible.
   always_comb begin
      rd_data_d = 64'h0;
      if (in_range) begin
         case (byte_addr)
            18'h000: rd_data_d = DFH;
            18'h008: rd_data_d = AFU_ID_L;
            18'h010: rd_data_d = AFU_ID_H;
            default: rd_data_d = 64'h0;
         endcase
      end
`ifdef HC_CSR_READBACK_EN
      if (is_dsm) rd_data_d = dsm_q;
      if (is_ctl) rd_data_d = {32'h0, ctl_q};
      for (int i = 0; i < NUM_BUFFERS; i++) begin
         if (is_buf && buf_idx == 6'(i))
            rd_data_d = size_sel ? {32'h0, buf_size_q[i]} : buf_addr_q[i];
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_valid_q <= 1'b0;
         rd_tid_q   <= '0;
         rd_data_q  <= '0;
      end else begin
         rd_valid_q <= cp2af_mmio_rd_valid;
         if (cp2af_mmio_rd_valid) begin
            rd_tid_q  <= cp2af_mmio_tid;
            rd_data_q <= rd_data_d;
         end
      end
   end

   for (genvar g = 0; g < NUM_BUFFERS; g++) begin : g_buf
      assign hc_buffer_address[g*64 +: 64] = buf_addr_q[g];
      assign hc_buffer_size[g*32 +: 32]    = buf_size_q[g];
   end

   assign af2cp_mmio_rd_valid = rd_valid_q;
   assign af2cp_mmio_tid      = rd_tid_q;
   assign af2cp_mmio_data     = rd_data_q;
   assign hc_dsm_base         = dsm_q;
   assign hc_control          = ctl_q;
   assign hc_soft_reset       = (state_q == S_CTL_RESET);
   assign hc_running          = (state_q == S_CTL_RUN);
   assign hc_start            = start_q;

endmodule

// File: tb/tb_hc_csr.sv
// tb/tb_hc_csr.sv - directed self-checking bench for hc_csr
// Expected readback values follow HC_CSR_READBACK_EN when it is defined for the build.
module tb_hc_csr;

   localparam logic [63:0] ID_L = 64'h0123_4567_89AB_CDEF;
   localparam logic [63:0] ID_H = 64'hFEDC_BA98_7654_3210;
   localparam logic [63:0] DFH  = 64'h1000_0100_0000_0000;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         rd_valid = 1'b0, wr_valid = 1'b0;
   logic [15:0]  address = '0;
   logic [8:0]   tid = '0;
   logic [63:0]  wdata = '0;
   logic         rsp_valid;
   logic [8:0]   rsp_tid;
   logic [63:0]  rsp_data;
   logic [63:0]  dsm_base;
   logic [127:0] buf_address;
   logic [63:0]  buf_size;
   logic [31:0]  control;
   logic         soft_reset, start, running;

   int n_vec = 0;
   int n_err = 0;

   hc_csr #(.NUM_BUFFERS(2), .AFU_ID_L(ID_L), .AFU_ID_H(ID_H)) dut (
      .clk                 (clk),
      .reset               (reset),
      .cp2af_mmio_rd_valid (rd_valid),
      .cp2af_mmio_wr_valid (wr_valid),
      .cp2af_mmio_address  (address),
      .cp2af_mmio_tid      (tid),
      .cp2af_mmio_data     (wdata),
      .af2cp_mmio_rd_valid (rsp_valid),
      .af2cp_mmio_tid      (rsp_tid),
      .af2cp_mmio_data     (rsp_data),
      .hc_dsm_base         (dsm_base),
      .hc_buffer_address   (buf_address),
      .hc_buffer_size      (buf_size),
      .hc_control          (control),
      .hc_soft_reset       (soft_reset),
      .hc_start            (start),
      .hc_running          (running)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mmio_write(input logic [17:0] byte_addr, input logic [63:0] d);
      address  = byte_addr[17:2];
      wdata    = d;
      wr_valid = 1'b1;
      tick();
      wr_valid = 1'b0;
   endtask

   task automatic mmio_read(input logic [17:0] byte_addr, input logic [8:0] t);
      address  = byte_addr[17:2];
      tid      = t;
      rd_valid = 1'b1;
      tick();
      rd_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      n_vec++; if (soft_reset !== 1'b1) begin n_err++; $display("FAIL reset_soft_reset got=%b exp=1", soft_reset); end
      n_vec++; if ({running, start, rsp_valid} !== 3'b000) begin n_err++; $display("FAIL reset_levels got=%b exp=000", {running, start, rsp_valid}); end
      n_vec++; if ({dsm_base, control, buf_address, buf_size} !== '0) begin n_err++; $display("FAIL reset_regs got nonzero dsm=%h ctl=%h", dsm_base, control); end
      mmio_read(18'h000, 9'h01A);
      n_vec++; if (rsp_valid !== 1'b1 || rsp_tid !== 9'h01A) begin n_err++; $display("FAIL dfh_rsp got v=%b tid=%h exp v=1 tid=01a", rsp_valid, rsp_tid); end
      n_vec++; if (rsp_data !== DFH) begin n_err++; $display("FAIL dfh_data got=%h exp=%h", rsp_data, DFH); end
      n_vec++; if (soft_reset !== 1'b1) begin n_err++; $display("FAIL dfh_soft_reset got=%b exp=1", soft_reset); end
      tick();
      n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rsp_single got=%b exp=0", rsp_valid); end
   endtask

   task automatic test_writes();
      logic [63:0] exp_rb;
      mmio_write(18'h110, 64'h0000_0001_2345_6780);
      n_vec++; if (dsm_base !== 64'h0000_0001_2345_6780) begin n_err++; $display("FAIL dsm_write got=%h exp=123456780", dsm_base); end
      mmio_write(18'h128, 64'h40);
      n_vec++; if (buf_size[31:0] !== 32'h40) begin n_err++; $display("FAIL buf0_size got=%h exp=40", buf_size[31:0]); end
      mmio_write(18'h120, 64'h0000_0000_ABCD_0000);
      n_vec++; if (buf_address[63:0] !== 64'hABCD_0000) begin n_err++; $display("FAIL buf0_addr got=%h exp=abcd0000", buf_address[63:0]); end
      mmio_write(18'h140, 64'h5555_5555_5555_5555);
      mmio_write(18'h148, 64'h6666_6666);
      mmio_write(18'h510, 64'h7777_7777_7777_7777);
      n_vec++; if (dsm_base !== 64'h0000_0001_2345_6780 || buf_address !== 128'hABCD_0000 || buf_size !== 64'h40 || control !== 32'h0)
         begin n_err++; $display("FAIL ignored_writes got dsm=%h addr=%h size=%h ctl=%h", dsm_base, buf_address, buf_size, control); end
`ifdef HC_CSR_READBACK_EN
      exp_rb = 64'h0000_0001_2345_6780;
`else
      exp_rb = 64'h0;
`endif
      mmio_read(18'h110, 9'h055);
      n_vec++; if (rsp_data !== exp_rb || rsp_tid !== 9'h055) begin n_err++; $display("FAIL dsm_read got=%h tid=%h exp=%h tid=055", rsp_data, rsp_tid, exp_rb); end
   endtask

   task automatic test_control();
      mmio_write(18'h118, 64'h3);
      n_vec++; if ({start, running, soft_reset} !== 3'b001 || control !== 32'h3) begin n_err++; $display("FAIL start_in_reset got s/r/sr=%b ctl=%h exp=001 ctl=3", {start, running, soft_reset}, control); end
      mmio_write(18'h118, 64'h1);
      n_vec++; if ({start, running, soft_reset} !== 3'b000) begin n_err++; $display("FAIL deassert got=%b exp=000", {start, running, soft_reset}); end
      mmio_write(18'h118, 64'h3);
      n_vec++; if ({start, running} !== 2'b11) begin n_err++; $display("FAIL start_pulse got=%b exp=11", {start, running}); end
      tick();
      n_vec++; if ({start, running} !== 2'b01) begin n_err++; $display("FAIL start_one_cycle got=%b exp=01", {start, running}); end
      mmio_write(18'h118, 64'h3);
      n_vec++; if ({start, running} !== 2'b01) begin n_err++; $display("FAIL second_start got=%b exp=01", {start, running}); end
      mmio_write(18'h118, 64'h5);
      n_vec++; if (running !== 1'b1 || control !== 32'h5) begin n_err++; $display("FAIL other_value got run=%b ctl=%h exp run=1 ctl=5", running, control); end
      mmio_write(18'h118, 64'h7);
      n_vec++; if ({start, running, soft_reset} !== 3'b000) begin n_err++; $display("FAIL stop got=%b exp=000", {start, running, soft_reset}); end
      mmio_write(18'h118, 64'h0);
      n_vec++; if (soft_reset !== 1'b1 || control !== 32'h0) begin n_err++; $display("FAIL assert_rst got sr=%b ctl=%h exp sr=1 ctl=0", soft_reset, control); end
   endtask

   task automatic test_same_cycle();
      logic [63:0] exp_rb;
      address  = 18'h130 >> 2;
      wdata    = 64'hDEAD_BEEF_0000_1000;
      tid      = 9'h133;
      wr_valid = 1'b1;
      rd_valid = 1'b1;
      tick();
      wr_valid = 1'b0;
      rd_valid = 1'b0;
      n_vec++; if (rsp_valid !== 1'b1 || rsp_data !== 64'h0) begin n_err++; $display("FAIL rw_old_value got v=%b d=%h exp v=1 d=0", rsp_valid, rsp_data); end
      n_vec++; if (buf_address[127:64] !== 64'hDEAD_BEEF_0000_1000) begin n_err++; $display("FAIL rw_write got=%h exp=deadbeef00001000", buf_address[127:64]); end
`ifdef HC_CSR_READBACK_EN
      exp_rb = 64'hDEAD_BEEF_0000_1000;
`else
      exp_rb = 64'h0;
`endif
      mmio_read(18'h130, 9'h134);
      n_vec++; if (rsp_data !== exp_rb) begin n_err++; $display("FAIL rw_later_read got=%h exp=%h", rsp_data, exp_rb); end
   endtask

   task automatic test_back_to_back();
      logic [17:0] addrs [4] = '{18'h008, 18'h010, 18'h000, 18'h018};
      logic [63:0] exps  [4] = '{ID_L, ID_H, DFH, 64'h0};
      for (int i = 0; i < 4; i++) begin
         address  = addrs[i][17:2];
         tid      = 9'(9'h100 + i);
         rd_valid = 1'b1;
         tick();
         n_vec++; if (rsp_valid !== 1'b1 || rsp_tid !== 9'(9'h100 + i) || rsp_data !== exps[i])
            begin n_err++; $display("FAIL b2b_%0d got v=%b tid=%h d=%h exp d=%h", i, rsp_valid, rsp_tid, rsp_data, exps[i]); end
      end
      rd_valid = 1'b0;
      tick();
      n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL b2b_end got=%b exp=0", rsp_valid); end
   endtask

   task automatic test_reset_midrun();
      mmio_write(18'h118, 64'h1);
      mmio_write(18'h118, 64'h3);
      n_vec++; if (running !== 1'b1) begin n_err++; $display("FAIL midrun_setup got=%b exp=1", running); end
      address  = 18'h000 >> 2;
      tid      = 9'h0EE;
      rd_valid = 1'b1;
      reset    = 1'b1;
      tick();
      rd_valid = 1'b0;
      reset    = 1'b0;
      n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL midrun_rsp got=%b exp=0", rsp_valid); end
      n_vec++; if ({running, soft_reset, start} !== 3'b010) begin n_err++; $display("FAIL midrun_state got=%b exp=010", {running, soft_reset, start}); end
      n_vec++; if ({dsm_base, control, buf_address, buf_size} !== '0) begin n_err++; $display("FAIL midrun_regs got dsm=%h addr=%h size=%h", dsm_base, buf_address, buf_size); end
      tick();
      n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL midrun_late_rsp got=%b exp=0", rsp_valid); end
   endtask

   initial begin
      test_reset();
      test_writes();
      test_control();
      test_same_cycle();
      test_back_to_back();
      test_reset_midrun();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
